// File: rtl/uart_rx_mmio.sv
// -----------------------------------------------------------------------------
// uart_rx_mmio
//   8N1 serial receiver (LSB first) with a small RX FIFO. The FIFO is read
//   through a two-register memory-mapped port, and a level interrupt stays
//   high while data is waiting.
//
// Ports
//   clk         in   1   system clock, all state on rising edge
//   reset       in   1   asynchronous, active-high reset
//   uart_input  in   1   serial RX line, idle high, asynchronous to clk
//   rd_en       in   1   MMIO read strobe, one cycle per access
//   rd_addr     in   1   0 = DATA (pops FIFO), 1 = STATUS
//   rd_data     out  32  read data, combinational from rd_addr
//   rx_irq      out  1   high while the FIFO is non-empty
//
// STATUS layout: {27'b0, overrun, frame_err, busy, full, not_empty}
// -----------------------------------------------------------------------------
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_input,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rd_data,
    output logic        rx_irq
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; reset to the idle (high) line level so that
    // leaving reset never looks like a start edge by itself.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_rxs;

    // NOTE: clocked state always uses <= so every flop samples the
    // pre-edge value of its neighbours; = here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= uart_input;
            r_rxs   <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shreg;
    logic            r_push_vld;   // one-cycle strobe, cycle after stop sample
    logic [7:0]      r_push_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // Half a bit in: re-check the line to reject glitches
                    // and align all later samples to mid-bit.
                    if (r_timer == T_HALF) begin
                        r_timer <= '0;
                        if (!r_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_timer == T_FULL) begin
                        r_timer            <= '0;
                        r_shreg[r_bit_idx] <= r_rxs;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_timer == T_FULL) begin
                        r_timer <= '0;
                        if (r_rxs) begin
                            r_push_vld  <= 1'b1;
                            r_push_data <= r_shreg;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    // A break or stuck-low line must not start a new frame.
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_frame_set;
    logic w_busy;

    assign w_frame_set = (r_state == S_STOP) && (r_timer == T_FULL) && !r_rxs;
    assign w_busy      = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_not_empty;
    logic w_pop;
    logic w_wr;
    logic w_stat_rd;
    logic w_overrun_set;

    assign w_full        = (r_count == C_FULL);
    assign w_not_empty   = (r_count != '0);
    assign w_pop         = rd_en && !rd_addr && w_not_empty;
    assign w_stat_rd     = rd_en && rd_addr;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr          = r_push_vld && (!w_full || w_pop);
    assign w_overrun_set = r_push_vld && w_full && !w_pop;

    // NOTE: the storage array has no reset; it is only ever observed
    // through rd_ptr when count is non-zero, so its contents at reset are
    // irrelevant and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as a STATUS read wins.
    // ------------------------------------------------------------------
    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_stat_rd) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (w_stat_rd) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // NOTE: rd_data is given a default before any branch so the
    // combinational block cannot infer a latch on an uncovered path.
    always_comb begin
        rd_data = '0;
        if (rd_addr) begin
            rd_data = {27'b0, r_overrun, r_frame_err, w_busy, w_full, w_not_empty};
        end else if (w_not_empty) begin
            rd_data = {24'b0, r_mem[r_rd_ptr]};
        end
    end

    assign rx_irq = w_not_empty;

endmodule
